// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_B/SZ_H/SZ_W : request size encodings (3 is illegal)
//   RAM_WORD_BYTES : bytes moved by every RAM access
//   lsu_state_e    : FSM states of lsu_mem_port
package lsu_pkg;

    localparam int unsigned RAM_WORD_BYTES = 4;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCapt,
        StWr,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//   size, is_unsigned : request size and zero-extend flag
//   raw_word          : 32-bit little-endian word read from RAM
//   wdata             : store data (low bytes used)
//   load_data         : byte/half/word from raw_word, sign- or zero-extended to XLEN
//   store_word        : raw_word with its low 1/2/4 bytes replaced by wdata
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [31:0]     raw_word,
    input  logic [31:0]     wdata,
    output logic [XLEN-1:0] load_data,
    output logic [31:0]     store_word
);

    logic sign_b;
    logic sign_h;
    logic sign_w;

    assign sign_b = ~is_unsigned & raw_word[7];
    assign sign_h = ~is_unsigned & raw_word[15];
    assign sign_w = ~is_unsigned & raw_word[31];

    always_comb begin
        load_data  = '0;
        store_word = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{(XLEN-8){sign_b}}, raw_word[7:0]};
                store_word = {raw_word[31:8], wdata[7:0]};
            end
            SZ_H: begin
                load_data  = {{(XLEN-16){sign_h}}, raw_word[15:0]};
                store_word = {raw_word[31:16], wdata[15:0]};
            end
            SZ_W: begin
                load_data  = {{(XLEN-32){sign_w}}, raw_word};
                store_word = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a byte-addressed data RAM with 1-cycle
// registered read that always moves 4 bytes at addr..addr+3 (little-endian).
//   clk, reset (async, active-high)
//   req_*  : one request at a time, accepted on req_valid & req_ready
//   resp_* : single-cycle completion pulse with extended load data / fault
//   mem_*  : RAM port (write enable, address, data in, data out)
// Sub-word stores are done as read-modify-write. All outputs are registered.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise they go to the RAM as-is.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic            rvalid_q, rvalid_d;
    logic            rfault_q, rfault_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mwe_q, mwe_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [31:0]     mwdata_q, mwdata_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     wdata_q, wdata_d;

    logic [XLEN:0]   end_addr;
    logic            out_of_range;
    logic            misaligned;
    logic            fault;
    logic [XLEN-1:0] load_data;
    logic [31:0]     store_word;
    logic            unused_hi;

    // Extra bit keeps addresses near 2^XLEN from wrapping back into range.
    assign end_addr     = {1'b0, req_addr} + (XLEN+1)'(RAM_WORD_BYTES);
    assign out_of_range = end_addr > (XLEN+1)'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign fault = (req_size == 2'd3) || out_of_range || misaligned;

    // Only the low word of either data bus carries meaning.
    assign unused_hi = ^{req_wdata[XLEN-1:32], mem_rdata[XLEN-1:32]};

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .raw_word    (mem_rdata[31:0]),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rfault_q <= 1'b0;
            rdata_q  <= '0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            we_q     <= 1'b0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rfault_q <= rfault_d;
            rdata_q  <= rdata_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        rvalid_d = rvalid_q;
        rfault_d = rfault_q;
        rdata_d  = rdata_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    ready_d  = 1'b0;
                    we_d     = req_we;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    wdata_d  = req_wdata[31:0];
                    rdata_d  = '0;
                    rfault_d = 1'b0;
                    if (fault) begin
                        // No RAM access at all for a faulting request.
                        rfault_d = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = StResp;
                    end else if (!req_we || (req_size != SZ_W)) begin
                        maddr_d = req_addr;
                        mwe_d   = 1'b0;
                        state_d = StRd;
                    end else begin
                        maddr_d  = req_addr;
                        mwdata_d = req_wdata[31:0];
                        mwe_d    = 1'b1;
                        state_d  = StWr;
                    end
                end
            end
            StRd: begin
                state_d = StCapt;
            end
            StCapt: begin
                if (we_q) begin
                    mwdata_d = store_word;
                    mwe_d    = 1'b1;
                    state_d  = StWr;
                end else begin
                    rdata_d  = load_data;
                    rvalid_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StWr: begin
                mwe_d    = 1'b0;
                rvalid_d = 1'b1;
                state_d  = StResp;
            end
            StResp: begin
                rvalid_d = 1'b0;
                ready_d  = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_fault = rfault_q;
    assign resp_rdata = rdata_q;
    assign mem_we     = mwe_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = {{(XLEN-32){1'b0}}, mwdata_q};

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port with a behavioural 1 KiB RAM
// (registered read, 4-byte little-endian access, preloaded with i ^ 0x88).
module tb_lsu_mem_port;

    localparam logic [1:0] B = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] W = 2'd2;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        fault;
    } req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        fault;
        logic [3:0]  lat;
        logic [3:0]  wecnt;
        logic        pulse_ok;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    resp_t sb[$];

    logic [7:0] ram [1024];
    logic       ram_load;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h88;
    endfunction

    function automatic logic [9:0] ba(input logic [63:0] a, input int k);
        return 10'(a[9:0] + 10'(k));
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) ram[ba(mem_addr, k)] <= mem_wdata[8*k +: 8];
        end
        mem_rdata <= {32'h0, ram[ba(mem_addr, 3)], ram[ba(mem_addr, 2)],
                      ram[ba(mem_addr, 1)], ram[ba(mem_addr, 0)]};
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic req_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input logic fault);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr;
        r.wdata = wdata; r.rdata = rdata; r.fault = fault;
        return r;
    endfunction

    // Expected response: latency 1 fault, 2 SW, 3 load, 4 SB/SH; one mem_we per store.
    function automatic resp_t expect_of(input req_t r);
        resp_t e;
        e.rdata    = r.rdata;
        e.fault    = r.fault;
        e.lat      = r.fault ? 4'd1 : (r.we ? ((r.size == W) ? 4'd2 : 4'd4) : 4'd3);
        e.wecnt    = (r.we && !r.fault) ? 4'd1 : 4'd0;
        e.pulse_ok = 1'b1;
        return e;
    endfunction

    task automatic issue(input req_t r, output resp_t obs);
        int n;
        obs = '0;
        obs.lat = 4'hF;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = r.we; req_size = r.size; req_unsigned = r.uns;
        req_addr = r.addr; req_wdata = r.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (mem_we === 1'b1) obs.wecnt = obs.wecnt + 4'd1;
            if (resp_valid === 1'b1) begin
                obs.lat   = 4'(c);
                obs.rdata = resp_rdata;
                obs.fault = resp_fault;
                @(posedge clk);
                #1;
                obs.pulse_ok = (resp_valid === 1'b0) && (req_ready === 1'b1) && (mem_we === 1'b0);
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [195:0] exp_v;
        exp_v = {1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0};
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_fault, resp_rdata, mem_we, mem_addr, mem_wdata} !== exp_v) begin
            errors++;
            $display("FAIL reset_values: got ready=%b rv=%b flt=%b rdata=%h we=%b addr=%h wdata=%h, want ready=1 rest 0",
                     req_ready, resp_valid, resp_fault, resp_rdata, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        ram_load = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b rv=%b we=%b, want ready=1 rv=0 we=0",
                     req_ready, resp_valid, mem_we);
        end
    endtask

    task automatic run_list(input string name, input req_t reqs[$]);
        resp_t obs, exp;
        foreach (reqs[i]) begin
            sb.push_back(expect_of(reqs[i]));
            issue(reqs[i], obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s[%0d]: got rdata=%h fault=%b lat=%0d we=%0d pulse=%b, want rdata=%h fault=%b lat=%0d we=%0d pulse=%b",
                         name, i, obs.rdata, obs.fault, obs.lat, obs.wecnt, obs.pulse_ok,
                         exp.rdata, exp.fault, exp.lat, exp.wecnt, exp.pulse_ok);
            end
        end
    endtask

    task automatic test_word();
        req_t q[$];
        q.push_back(mk(1, W, 0, 64'h10, 64'h12345678DEADBEEF, 64'h0, 0));
        q.push_back(mk(0, W, 0, 64'h10, 64'h0, 64'hFFFFFFFFDEADBEEF, 0));
        q.push_back(mk(0, W, 1, 64'h10, 64'h0, 64'h00000000DEADBEEF, 0));
        run_list("word", q);
    endtask

    task automatic test_sub_store();
        req_t q[$];
        q.push_back(mk(1, B, 0, 64'h11, 64'hFFFFFFFFFFFFFF5A, 64'h0, 0));
        q.push_back(mk(0, W, 0, 64'h10, 64'h0, 64'hFFFFFFFFDEAD5AEF, 0));
        q.push_back(mk(0, B, 1, 64'h11, 64'h0, 64'h000000000000005A, 0));
        q.push_back(mk(1, H, 0, 64'h18, 64'h00000000ABCD1234, 64'h0, 0));
        q.push_back(mk(0, W, 0, 64'h18, 64'h0, 64'hFFFFFFFF93921234, 0));
        run_list("sub_store", q);
    endtask

    task automatic test_half_byte();
        req_t q[$];
        q.push_back(mk(0, H, 0, 64'h12, 64'h0, 64'hFFFFFFFFFFFFDEAD, 0));
        q.push_back(mk(0, H, 1, 64'h12, 64'h0, 64'h000000000000DEAD, 0));
        q.push_back(mk(0, B, 0, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFFEF, 0));
        run_list("half_byte", q);
    endtask

    task automatic test_faults();
        req_t q[$];
        q.push_back(mk(0, W, 0, 64'h3FD, 64'h0, 64'h0, 1));
        q.push_back(mk(0, W, 0, 64'h3FC, 64'h0, 64'h0000000077767574, 0));
        q.push_back(mk(0, 2'd3, 0, 64'h0, 64'h0, 64'h0, 1));
        q.push_back(mk(0, W, 0, 64'hFFFFFFFFFFFFFFFE, 64'h0, 64'h0, 1));
        q.push_back(mk(1, W, 0, 64'h3FE, 64'h11223344, 64'h0, 1));
        q.push_back(mk(0, W, 0, 64'h3FC, 64'h0, 64'h0000000077767574, 0));
        run_list("faults", q);
    endtask

    task automatic test_reset_mid();
        int we_seen = 0;
        int rv_seen = 0;
        req_t q[$];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = B; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (mem_we === 1'b1) we_seen++;
        if (resp_valid === 1'b1) rv_seen++;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) we_seen++;
        if (resp_valid === 1'b1) rv_seen++;
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1) we_seen++;
            if (resp_valid === 1'b1) rv_seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1) we_seen++;
            if (resp_valid === 1'b1) rv_seen++;
        end
        checks++;
        if (we_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_we: got %0d mem_we cycles, want 0", we_seen);
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_resp: got %0d resp_valid cycles, want 0", rv_seen);
        end
        checks++;
        if ({req_ready, mem_addr, mem_wdata} !== {1'b1, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL reset_mid_state: got ready=%b addr=%h wdata=%h, want 1/0/0",
                     req_ready, mem_addr, mem_wdata);
        end
        q.push_back(mk(0, W, 0, 64'h20, 64'h0, 64'hFFFFFFFFABAAA9A8, 0));
        run_list("reset_mid_lw", q);
    endtask

    task automatic test_misalign();
        req_t q[$];
`ifdef LSU_MISALIGN_TRAP_EN
        q.push_back(mk(0, W, 0, 64'h11, 64'h0, 64'h0, 1));
        q.push_back(mk(0, H, 0, 64'h13, 64'h0, 64'h0, 1));
`else
        q.push_back(mk(0, W, 0, 64'h11, 64'h0, 64'hFFFFFFFF9CDEAD5A, 0));
        q.push_back(mk(0, H, 0, 64'h13, 64'h0, 64'hFFFFFFFFFFFF9CDE, 0));
`endif
        run_list("misalign", q);
    endtask

    initial begin
        reset = 1'b1;
        ram_load = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_word();
        test_sub_store();
        test_half_byte();
        test_faults();
        test_reset_mid();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
